tap_pipeline: RTL and testbench

- Parametrised successor to the fixed two-register capture/transform pair in our top-level designs.
- A DEPTH-stage registered pipeline carrying CH packed channels of WIDTH bits each, with a valid/ready handshake.
- Stage 0 captures the input. Stage 1 applies a per-channel selectable transform. Remaining stages are delay registers.
- Sits between the input capture logic and downstream consumers, which may apply backpressure.

---
 rtl/tap_pipeline_pkg.sv | 50 +++++
 rtl/tap_pipeline_stage.sv | 37 +++
 rtl/tap_pipeline.sv | 116 +++++++++++
 tb/tb_tap_pipeline.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_pipeline_pkg.sv
// Shared types and helpers for tap_pipeline.
// Holds the per-channel transform select encoding, the depth limit and the
// single-channel transform function used at the stage-1 input.
package tap_pipeline_pkg;

  // Deepest pipeline the block supports.
  localparam int TAP_MAX_DEPTH = 16;

  // Widest channel the transform helper can process.
  localparam int TAP_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_INC  = 2'd2,
    MODE_REV  = 2'd3
  } tap_mode_e;

  // Transform one channel. The channel is carried zero-extended in a
  // TAP_MAX_WIDTH vector. Only the low 'width' bits of the result are
  // meaningful, and the bits above them are forced to zero. The caller must
  // pass a constant width so that the bit-reverse loop folds into wiring.
  function automatic logic [TAP_MAX_WIDTH-1:0] tap_func(
    input logic [TAP_MAX_WIDTH-1:0] data,
    input tap_mode_e                mode,
    input int                       width
  );
    logic [TAP_MAX_WIDTH-1:0] mask;
    logic [TAP_MAX_WIDTH-1:0] res;
    if (width >= TAP_MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (TAP_MAX_WIDTH'(1) << width) - TAP_MAX_WIDTH'(1);
    end
    res = '0;
    case (mode)
      MODE_PASS: res = data;
      MODE_INV:  res = ~data;
      MODE_INC:  res = data + TAP_MAX_WIDTH'(1);
      MODE_REV: begin
        for (int i = 0; i < TAP_MAX_WIDTH; i++) begin
          if (i < width) res[i] = data[width-1-i];
        end
      end
      default:   res = data;
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/tap_pipeline_stage.sv
// One pipeline stage: a valid bit and a data word.
// On reset, both the valid bit and the data are cleared. Flush clears only the
// valid bit and leaves the data as it was. Data loads only when the incoming
// beat is valid, so a stage that holds no valid beat keeps its old contents.
module tap_pipe_stage #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_adv,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Stage register: flush wins over advance, and data moves only with a valid beat.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/tap_pipeline.sv
// tap_pipeline: a registered pipeline of DEPTH stages (2..16) that carries CH
// packed channels of WIDTH bits each.
// Stage 0 captures IN. Stage 1 loads a per-channel transform of stage 0,
// with the transform chosen by MODE. The remaining stages are delay registers.
//
// Handshake: a beat moves across a boundary when the upstream side is valid and
// the downstream side is ready in the same cycle. A stage can accept a beat when
// it is empty or when the stage after it is accepting. OUT_READY feeds the last
// stage. This ready chain is combinational, so a full pipeline that is being
// drained still accepts one beat per cycle, with no bubbles. FLUSH forces
// IN_READY low and clears every valid bit at the next edge.
//
// Optional build macro TAP_PIPELINE_LEVEL_COUNT_EN adds the LEVEL output. LEVEL
// is a registered count of the stages that hold a valid beat.
module tap_pipeline
  import tap_pipeline_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 2,
  parameter int DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [WIDTH*CH-1:0]         IN,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic [2*CH-1:0]             MODE,
  input  logic                        FLUSH,
  output logic [WIDTH*CH-1:0]         OUT,
  output logic                        OUT_VALID,
`ifdef TAP_PIPELINE_LEVEL_COUNT_EN
  output logic [$clog2(DEPTH+1)-1:0]  LEVEL,
`endif
  input  logic                        OUT_READY
);

  localparam int DW = WIDTH * CH;

  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_vin;
  logic [DEPTH-1:0] w_adv;
  logic [DW-1:0]    w_d   [DEPTH];
  logic [DW-1:0]    w_din [DEPTH];
  logic [DW-1:0]    w_fx;

  // Ready chain from the output back to the input. It is built with an
  // accumulator so that no vector depends on itself.
  always_comb begin
    logic acc;
    w_adv = '0;
    acc   = OUT_READY;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc      = acc | ~w_v[i];
      w_adv[i] = acc;
    end
  end

  assign w_vin = {w_v[DEPTH-2:0], IN_VALID};

  // Per-channel transform of stage 0. MODE is sampled as the beat enters stage 1.
  for (genvar k = 0; k < CH; k++) begin : g_fx
    assign w_fx[k*WIDTH +: WIDTH] = WIDTH'(tap_func(TAP_MAX_WIDTH'(w_d[0][k*WIDTH +: WIDTH]),
                                                    tap_mode_e'(MODE[2*k +: 2]), WIDTH));
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_in
      assign w_din[i] = IN;
    end else if (i == 1) begin : g_xf
      assign w_din[i] = w_fx;
    end else begin : g_dly
      assign w_din[i] = w_d[i-1];
    end

    tap_pipe_stage #(.W(DW)) u_stage (
      .CLK     (CLK),
      .RST     (RST),
      .i_adv   (w_adv[i]),
      .i_flush (FLUSH),
      .i_valid (w_vin[i]),
      .i_data  (w_din[i]),
      .o_valid (w_v[i]),
      .o_data  (w_d[i])
    );
  end

  assign IN_READY  = w_adv[0] & ~FLUSH;
  assign OUT       = w_d[DEPTH-1];
  assign OUT_VALID = w_v[DEPTH-1];

`ifdef TAP_PIPELINE_LEVEL_COUNT_EN
  localparam int LW = $clog2(DEPTH + 1);

  logic [LW-1:0] w_level_next;
  logic [LW-1:0] r_level;

  // Occupancy the stages will have after the coming edge.
  always_comb begin
    logic nv;
    w_level_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nv           = FLUSH ? 1'b0 : (w_adv[i] ? w_vin[i] : w_v[i]);
      w_level_next = w_level_next + LW'(nv);
    end
  end

  // Occupancy register. It stays in step with the stage valid bits.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_level <= '0;
    else      r_level <= w_level_next;
  end

  assign LEVEL = r_level;
`endif

endmodule

// File: tb/tb_tap_pipeline.sv
// Bench for tap_pipeline at its default parameters: WIDTH=8, CH=2, DEPTH=4.
// The reference model is a queue of transformed beats in acceptance order,
// plus a count of beats in flight. The model derives IN_READY from that count.
module tb_tap_pipeline;

  localparam int WIDTH = 8;
  localparam int CH    = 2;
  localparam int DEPTH = 4;
  localparam int DW    = WIDTH * CH;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] IN = '0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [2*CH-1:0] MODE = '0;
  logic          FLUSH = 1'b0;
  logic [DW-1:0] OUT;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
`ifdef TAP_PIPELINE_LEVEL_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] LEVEL;
  logic [$clog2(DEPTH+1)-1:0] s_level;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model state.
  logic [DW-1:0] exp_q[$];
  int            m_cnt = 0;
  int            cyc = 0;

  // Values sampled in the latest cycle.
  logic          s_in_ready, s_out_valid, s_exp_in_ready;
  logic          s_in_fire = 1'b0, s_out_fire, s_exp_ok;
  logic [DW-1:0] s_out = '0, s_exp = '0, p_out;
  logic          s_stall = 1'b0, p_stall = 1'b0;
  int            s_cyc, s_cnt;

  tap_pipeline #(.WIDTH(WIDTH), .CH(CH), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN        (IN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .MODE      (MODE),
    .FLUSH     (FLUSH),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
`ifdef TAP_PIPELINE_LEVEL_COUNT_EN
    .LEVEL     (LEVEL),
`endif
    .OUT_READY (OUT_READY)
  );

  // Clock.
  always #5 CLK = ~CLK;

  // Reference transform, built channel by channel from the mode definitions.
  function automatic logic [DW-1:0] ref_xform(input logic [DW-1:0] d, input logic [2*CH-1:0] m);
    logic [DW-1:0]    r;
    logic [WIDTH-1:0] c, o;
    int               mv;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      c  = d[k*WIDTH +: WIDTH];
      mv = int'(m[2*k +: 2]);
      o  = '0;
      if (mv == 0) o = c;
      else if (mv == 1) o = WIDTH'((1 << WIDTH) - 1 - int'(c));
      else if (mv == 2) o = WIDTH'((int'(c) + 1) % (1 << WIDTH));
      else for (int b = 0; b < WIDTH; b++) o = {o[WIDTH-2:0], c[b]};
      r[k*WIDTH +: WIDTH] = o;
    end
    return r;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    m_cnt   = 0;
    s_stall = 1'b0;
    p_stall = 1'b0;
  endtask

  // Advance one cycle. Outputs are sampled on the falling edge, then the model
  // is updated. The task returns one time unit after the rising edge.
  task automatic tick();
    @(negedge CLK);
    p_stall        = s_stall;
    p_out          = s_out;
    s_in_ready     = IN_READY;
    s_out_valid    = OUT_VALID;
    s_out          = OUT;
`ifdef TAP_PIPELINE_LEVEL_COUNT_EN
    s_level        = LEVEL;
`endif
    s_cyc          = cyc;
    s_cnt          = m_cnt;
    s_exp_in_ready = !FLUSH && ((m_cnt < DEPTH) || OUT_READY);
    s_in_fire      = IN_VALID && IN_READY;
    s_out_fire     = OUT_VALID && OUT_READY && !FLUSH;
    s_stall        = OUT_VALID && !OUT_READY && !FLUSH;
    s_exp_ok       = 1'b0;
    if (FLUSH) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (s_out_fire) begin
        if (exp_q.size() > 0) begin
          s_exp    = exp_q.pop_front();
          s_exp_ok = 1'b1;
        end
        if (m_cnt > 0) m_cnt--;
      end
      if (s_in_fire) begin
        exp_q.push_back(ref_xform(IN, MODE));
        m_cnt++;
      end
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if (OUT !== '0) begin n_errors++; $display("FAIL reset_out: got %h required 0", OUT); end
    n_checks++;
    if (OUT_VALID !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b required 0", OUT_VALID); end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_checks++;
    if (IN_READY !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b required 1", IN_READY); end
    @(posedge CLK);
    #1;
    clear_model();
  endtask

  task automatic test_stream();
    logic [DW-1:0] beats[2];
    logic [DW-1:0] gold[2];
    int acc_cyc[2];
    int out_cyc[2];
    int sent, seen;
    beats[0] = 16'h0102; beats[1] = 16'h0304;
    gold[0]  = 16'h0202; gold[1]  = 16'h0404;
    sent = 0; seen = 0;
    MODE = 4'b1000;
    OUT_READY = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (sent < 2) begin IN = beats[sent]; IN_VALID = 1'b1; end
      else IN_VALID = 1'b0;
      tick();
      n_checks++;
      if (s_in_ready !== s_exp_in_ready) begin
        n_errors++; $display("FAIL stream_in_ready: got %b required %b", s_in_ready, s_exp_in_ready);
      end
      if (s_in_fire && sent < 2) begin acc_cyc[sent] = s_cyc; sent++; end
      if (s_out_fire) begin
        n_checks++;
        if (!s_exp_ok || s_out !== s_exp) begin
          n_errors++; $display("FAIL stream_data_model: got %h required %h", s_out, s_exp);
        end
        if (seen < 2) begin
          n_checks++;
          if (s_out !== gold[seen]) begin
            n_errors++; $display("FAIL stream_data_gold: got %h required %h", s_out, gold[seen]);
          end
          out_cyc[seen] = s_cyc;
        end
        seen++;
      end
    end
    IN_VALID = 1'b0;
    n_checks++;
    if (seen != 2 || sent != 2) begin
      n_errors++; $display("FAIL stream_count: got %0d out/%0d in required 2/2", seen, sent);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (out_cyc[i] - acc_cyc[i] != DEPTH) begin
          n_errors++; $display("FAIL stream_latency: got %0d required %0d", out_cyc[i] - acc_cyc[i], DEPTH);
        end
      end
    end
  endtask

  task automatic test_transform();
    logic [DW-1:0]   din[2];
    logic [2*CH-1:0] mv[2];
    logic [DW-1:0]   gold[2];
    int got;
    din[0] = 16'hA5FF; mv[0] = 4'b0110; gold[0] = 16'h5A00;
    din[1] = 16'h3C01; mv[1] = 4'b0011; gold[1] = 16'h3C80;
    OUT_READY = 1'b1;
    for (int t = 0; t < 2; t++) begin
      MODE = mv[t];
      IN = din[t];
      IN_VALID = 1'b1;
      got = 0;
      for (int c = 0; c < 12 && got == 0; c++) begin
        tick();
        if (s_in_fire) IN_VALID = 1'b0;
        if (s_out_fire) begin
          got = 1;
          n_checks++;
          if (!s_exp_ok || s_out !== s_exp) begin
            n_errors++; $display("FAIL xform_model: got %h required %h", s_out, s_exp);
          end
          n_checks++;
          if (s_out !== gold[t]) begin
            n_errors++; $display("FAIL xform_gold: got %h required %h", s_out, gold[t]);
          end
        end
      end
      IN_VALID = 1'b0;
      if (got == 0) begin
        n_checks++; n_errors++; $display("FAIL xform_timeout: got no output required %h", gold[t]);
      end
    end
  endtask

  task automatic test_backpressure();
    int accepts;
    MODE = 4'($urandom_range(0, 15));
    OUT_READY = 1'b0;
    IN = 16'($urandom);
    IN_VALID = 1'b1;
    accepts = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (s_in_ready !== s_exp_in_ready) begin
        n_errors++; $display("FAIL bp_in_ready: got %b required %b", s_in_ready, s_exp_in_ready);
      end
      if (p_stall) begin
        n_checks++;
        if (s_out_valid !== 1'b1 || s_out !== p_out) begin
          n_errors++; $display("FAIL bp_hold: got %h/%b required %h/1", s_out, s_out_valid, p_out);
        end
      end
      if (s_in_fire) begin accepts++; IN = 16'($urandom); end
    end
    n_checks++;
    if (accepts != DEPTH) begin n_errors++; $display("FAIL bp_accepts: got %0d required %0d", accepts, DEPTH); end
    OUT_READY = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 6) IN_VALID = 1'b0;
      tick();
      if (c == 0) begin
        n_checks++;
        if (s_in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready: got %b required 1", s_in_ready); end
      end
      n_checks++;
      if (s_in_ready !== s_exp_in_ready) begin
        n_errors++; $display("FAIL bp_drain_ready: got %b required %b", s_in_ready, s_exp_in_ready);
      end
      if (s_out_fire) begin
        n_checks++;
        if (!s_exp_ok || s_out !== s_exp) begin
          n_errors++; $display("FAIL bp_drain_data: got %h required %h", s_out, s_exp);
        end
      end
      if (s_in_fire) IN = 16'($urandom);
    end
    n_checks++;
    if (OUT_VALID !== 1'b0 || exp_q.size() != 0) begin
      n_errors++; $display("FAIL bp_drained: got valid=%b pending=%0d required 0/0", OUT_VALID, exp_q.size());
    end
  endtask

  task automatic test_flush();
    int sent;
    int leaks;
    OUT_READY = 1'b1;
    sent = 0;
    IN_VALID = 1'b1;
    while (sent < 3) begin
      IN = 16'($urandom);
      tick();
      if (s_in_fire) sent++;
      if (cyc > 100000) break;
    end
    IN_VALID = 1'b1;
    IN = 16'hDEAD;
    FLUSH = 1'b1;
    tick();
    n_checks++;
    if (s_in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready: got %b required 0", s_in_ready); end
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    tick();
    n_checks++;
    if (s_out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_out_valid: got %b required 0", s_out_valid); end
    leaks = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (s_out_valid) leaks++;
    end
    n_checks++;
    if (leaks != 0) begin n_errors++; $display("FAIL flush_leak: got %0d beats required 0", leaks); end
  endtask

  task automatic test_random();
    int fires;
    MODE = 4'($urandom_range(0, 15));
    IN_VALID = 1'b0;
    s_in_fire = 1'b0;
    fires = 0;
    for (int c = 0; c < 300; c++) begin
      if (!IN_VALID || s_in_fire) begin
        IN_VALID = ($urandom_range(0, 3) != 0);
        IN = 16'($urandom);
      end
      OUT_READY = ($urandom_range(0, 2) != 0);
      FLUSH = ($urandom_range(0, 40) == 0);
      tick();
      n_checks++;
      if (s_in_ready !== s_exp_in_ready) begin
        n_errors++; $display("FAIL rnd_in_ready: got %b required %b cyc %0d", s_in_ready, s_exp_in_ready, s_cyc);
      end
      if (s_cnt == 0) begin
        n_checks++;
        if (s_out_valid !== 1'b0) begin n_errors++; $display("FAIL rnd_empty_valid: got %b required 0", s_out_valid); end
      end
      if (p_stall) begin
        n_checks++;
        if (s_out_valid !== 1'b1 || s_out !== p_out) begin
          n_errors++; $display("FAIL rnd_hold: got %h/%b required %h/1", s_out, s_out_valid, p_out);
        end
      end
      if (s_out_fire) begin
        fires++;
        n_checks++;
        if (!s_exp_ok || s_out !== s_exp) begin
          n_errors++; $display("FAIL rnd_data: got %h required %h cyc %0d", s_out, s_exp, s_cyc);
        end
      end
    end
    FLUSH = 1'b0;
    OUT_READY = 1'b1;
    if (IN_VALID && !s_in_fire) begin
      for (int c = 0; c < 20 && !s_in_fire; c++) tick();
    end
    IN_VALID = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_out_fire) begin
        n_checks++;
        if (!s_exp_ok || s_out !== s_exp) begin
          n_errors++; $display("FAIL rnd_drain_data: got %h required %h", s_out, s_exp);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || OUT_VALID !== 1'b0) begin
      n_errors++; $display("FAIL rnd_lost: got pending=%0d valid=%b required 0/0", exp_q.size(), OUT_VALID);
    end
  endtask

  task automatic test_reset_midstream();
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    for (int c = 0; c < 6; c++) begin
      IN = 16'($urandom);
      tick();
    end
    IN_VALID = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    n_checks++;
    if (OUT !== '0) begin n_errors++; $display("FAIL midrst_out: got %h required 0", OUT); end
    n_checks++;
    if (OUT_VALID !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b required 0", OUT_VALID); end
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_checks++;
    if (IN_READY !== 1'b1) begin n_errors++; $display("FAIL midrst_in_ready: got %b required 1", IN_READY); end
    @(posedge CLK);
    #1;
    clear_model();
    OUT_READY = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (s_out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_stale: got valid=%b required 0", s_out_valid); end
    end
  endtask

`ifdef TAP_PIPELINE_LEVEL_COUNT_EN
  task automatic test_level();
    int sent;
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    sent = 0;
    for (int c = 0; c < 10 && sent < 3; c++) begin
      IN = 16'($urandom);
      tick();
      if (s_in_fire) sent++;
    end
    IN_VALID = 1'b0;
    tick();
    n_checks++;
    if (int'(s_level) != 3) begin n_errors++; $display("FAIL level_fill: got %0d required 3", s_level); end
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    tick();
    n_checks++;
    if (int'(s_level) != 0) begin n_errors++; $display("FAIL level_flush: got %0d required 0", s_level); end
  endtask
`endif

  // Watchdog.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  // Test sequence.
  initial begin
    test_reset();
    test_stream();
    test_transform();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_midstream();
`ifdef TAP_PIPELINE_LEVEL_COUNT_EN
    test_level();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
